// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-issue ALU between NREQ requesters.
// Optional macro ALU_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin.
module alu_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned OPW     = 5,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned TMO_CYC = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OPW-1:0]    req_opcode,
  input  logic [NREQ*32-1:0]     req_src1,
  input  logic [NREQ*32-1:0]     req_src2,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic [OPW-1:0]         alu_opcode,
  output logic [31:0]            alu_src1,
  output logic [31:0]            alu_src2,
  input  logic [31:0]            alu_result,
  input  logic                   alu_busy,
  input  logic                   alu_done,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [TAGW-1:0]        rsp_tag,
  output logic                   rsp_err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic [OPW-1:0]  alu_opcode_d;
  logic [DW-1:0]   alu_src1_d, alu_src2_d;
  logic [NREQ-1:0] rsp_valid_d;
  logic [DW-1:0]   rsp_result_d;
  logic [TAGW-1:0] rsp_tag_d;
  logic            rsp_err_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   win_next;
  logic [OPW-1:0]  sel_opcode;
  logic [DW-1:0]   sel_src1, sel_src2;
  logic [TAGW-1:0] sel_tag;

  // Winner search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    if (win_idx == IW'(NREQ - 1)) win_next = '0;
    else                          win_next = win_idx + IW'(1);
  end

  // Payload mux for the current winner.
  always_comb begin
    sel_opcode = '0;
    sel_src1   = '0;
    sel_src2   = '0;
    sel_tag    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == win_idx) begin
        sel_opcode = req_opcode[k*OPW +: OPW];
        sel_src1   = req_src1[k*DW +: DW];
        sel_src2   = req_src2[k*DW +: DW];
        sel_tag    = req_tag[k*TAGW +: TAGW];
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (RST_N && (state_q == S_IDLE) && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    tag_d        = tag_q;
    alu_opcode_d = alu_opcode;
    alu_src1_d   = alu_src1;
    alu_src2_d   = alu_src2;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_tag_d    = rsp_tag;
    rsp_err_d    = rsp_err;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_ISSUE;
          grant_d      = win_idx;
          tag_d        = sel_tag;
          alu_opcode_d = sel_opcode;
          alu_src1_d   = sel_src1;
          alu_src2_d   = sel_src2;
          tmo_cnt_d    = '0;
`ifdef ALU_ARB_PRIO0_EN
          if (win_idx != '0) rr_ptr_d = win_next;
`else
          rr_ptr_d = win_next;
`endif
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (alu_busy) begin
          if (tmo_cnt_q == TW'(TMO_CYC - 1)) begin
            state_d      = S_RESP;
            rsp_valid_d  = NREQ'(1) << grant_q;
            rsp_result_d = '0;
            rsp_tag_d    = tag_q;
            rsp_err_d    = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end else begin
          state_d      = S_RESP;
          rsp_valid_d  = NREQ'(1) << grant_q;
          rsp_result_d = alu_done ? alu_result : '0;
          rsp_tag_d    = tag_q;
          rsp_err_d    = ~alu_done;
        end
      end

      S_RESP: begin
        if (rsp_ready[grant_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      tmo_cnt_q  <= '0;
      tag_q      <= '0;
      alu_opcode <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tag_q      <= tag_d;
      alu_opcode <= alu_opcode_d;
      alu_src1   <= alu_src1_d;
      alu_src2   <= alu_src2_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_tag    <= rsp_tag_d;
      rsp_err    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a behavioural ALU stand-in and a rule-level model.
module tb_alu_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned OPW     = 5;
  localparam int unsigned TAGW    = 4;
  localparam int unsigned TMO_CYC = 16;
  localparam int unsigned IW      = 2;

  localparam logic [OPW-1:0] OP_ADD = 5'd0;
  localparam logic [OPW-1:0] OP_SUB = 5'd1;
  localparam logic [OPW-1:0] OP_AND = 5'd2;
  localparam logic [OPW-1:0] OP_OR  = 5'd3;
  localparam logic [OPW-1:0] OP_XOR = 5'd4;
  localparam logic [OPW-1:0] OP_SLT = 5'd5;
  localparam logic [OPW-1:0] OP_BAD = 5'd31;

  logic                 CLK;
  logic                 RST_N;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_opcode;
  logic [NREQ*32-1:0]   req_src1;
  logic [NREQ*32-1:0]   req_src2;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [OPW-1:0]       alu_opcode;
  logic [31:0]          alu_src1;
  logic [31:0]          alu_src2;
  logic [31:0]          alu_result;
  logic                 alu_busy;
  logic                 alu_done;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_result;
  logic [TAGW-1:0]      rsp_tag;
  logic                 rsp_err;

  logic force_busy;
  int   n_tests;
  int   n_fail;
  int   model_ptr;

  logic [OPW-1:0]  r_op  [NREQ];
  logic [31:0]     r_s1  [NREQ];
  logic [31:0]     r_s2  [NREQ];
  logic [TAGW-1:0] r_tag [NREQ];

  alu_arbiter #(.NREQ(NREQ), .OPW(OPW), .TAGW(TAGW), .TMO_CYC(TMO_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_busy(alu_busy), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Illegal opcodes return garbage with done=0; the arbiter must zero it.
  function automatic logic [32:0] alu_fn(input logic [OPW-1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      OP_ADD:  return {1'b1, a + b};
      OP_SUB:  return {1'b1, a - b};
      OP_AND:  return {1'b1, a & b};
      OP_OR:   return {1'b1, a | b};
      OP_XOR:  return {1'b1, a ^ b};
      OP_SLT:  return {1'b1, 31'd0, ($signed(a) < $signed(b))};
      default: return {1'b0, a ^ 32'hdead_beef};
    endcase
  endfunction

  always_ff @(posedge CLK) {alu_done, alu_result} <= alu_fn(alu_opcode, alu_src1, alu_src2);
  assign alu_busy = force_busy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      req_opcode[i*OPW +: OPW] = r_op[i];
      req_src1[i*32 +: 32]     = r_s1[i];
      req_src2[i*32 +: 32]     = r_s2[i];
      req_tag[i*TAGW +: TAGW]  = r_tag[i];
    end
    req_valid = mask;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] m);
`ifdef ALU_ARB_PRIO0_EN
    if (m[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (model_ptr + k) % NREQ;
      if (m[IW'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_advance(input int w);
`ifdef ALU_ARB_PRIO0_EN
    if (w == 0) return;
`endif
    model_ptr = (w + 1) % NREQ;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < NREQ; i++) begin
      r_op[i]  = ($urandom_range(0, 7) < 6) ? OPW'($urandom_range(0, 5)) : OPW'($urandom_range(6, 31));
      r_s1[i]  = $urandom;
      r_s2[i]  = $urandom;
      r_tag[i] = TAGW'($urandom);
    end
  endtask

  // One full transaction, entered and left just after a negedge with the DUT in IDLE.
  task automatic run_op(input logic [NREQ-1:0] mask, input int bp, input bit drop_winner);
    logic [NREQ-1:0] oh;
    logic [32:0]     ar;
    logic [31:0]     exp_res;
    logic            exp_err;
    int              w, lat, exp_lat;
    rsp_ready = '0;
    drive_reqs(mask);
    #1;
    w  = model_pick(mask);
    oh = (w >= 0) ? (NREQ'(1) << w) : '0;
    check_eq("req_ready", 64'(req_ready), 64'(oh));
    if (w < 0) return;
    ar      = alu_fn(r_op[w], r_s1[w], r_s2[w]);
    exp_err = force_busy || !ar[32];
    exp_res = exp_err ? 32'd0 : ar[31:0];
    exp_lat = force_busy ? int'(TMO_CYC) + 2 : 3;
    @(posedge CLK);
    model_advance(w);
    #1;
    if (drop_winner) req_valid[IW'(w)] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        check_eq("alu_opcode", 64'(alu_opcode), 64'(r_op[w]));
        check_eq("alu_src1", 64'(alu_src1), 64'(r_s1[w]));
        check_eq("alu_src2", 64'(alu_src2), 64'(r_s2[w]));
      end
      if (rsp_valid != '0) break;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(oh));
    check_eq("rsp_result", 64'(rsp_result), 64'(exp_res));
    check_eq("rsp_tag", 64'(rsp_tag), 64'(r_tag[w]));
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    for (int c = 0; c < bp; c++) begin
      rsp_ready = ~oh;
      @(negedge CLK);
      check_eq("bp_valid", 64'(rsp_valid), 64'(oh));
      check_eq("bp_result", 64'(rsp_result), 64'(exp_res));
      check_eq("bp_no_accept", 64'(req_ready), 64'(0));
    end
    rsp_ready = oh;
    @(posedge CLK);
    #1 rsp_ready = '0;
    @(negedge CLK);
    check_eq("rsp_valid_fall", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    model_ptr  = 0;
    force_busy = 1'b0;
    rsp_ready  = '0;
    RST_N      = 1'b0;
    randomize_reqs();
    drive_reqs('1);

    // Reset with every requester asserting valid.
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_alu_opcode", 64'(alu_opcode), 64'(0));
    check_eq("rst_alu_src1", 64'(alu_src1), 64'(0));
    check_eq("rst_alu_src2", 64'(alu_src2), 64'(0));
    check_eq("rst_rsp_result", 64'(rsp_result), 64'(0));
    check_eq("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
    req_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("idle_rsp_valid", 64'(rsp_valid), 64'(0));

    // Contention: all valid held, rr_ptr starts at 0.
`ifdef ALU_ARB_PRIO0_EN
    repeat (3) run_op('1, 0, 1'b0);
`else
    repeat (5) run_op('1, 0, 1'b0);
`endif
    req_valid = '0;

    // Single add on requester 1.
    randomize_reqs();
    r_op[1] = OP_ADD; r_s1[1] = 32'd5; r_s2[1] = 32'd7; r_tag[1] = 4'd3;
    run_op(4'b0010, 0, 1'b1);

    // Illegal opcode, then a normal op.
    r_op[2] = OP_BAD; r_tag[2] = 4'd9;
    run_op(4'b0100, 0, 1'b1);
    r_op[0] = OP_SUB; r_s1[0] = 32'd100; r_s2[0] = 32'd1;
    run_op(4'b0001, 0, 1'b1);

    // Backpressure on a signed compare, another requester left waiting.
    r_op[3] = OP_SLT; r_s1[3] = 32'hffff_ffff; r_s2[3] = 32'd1;
    r_op[0] = OP_SLT; r_s1[0] = 32'hffff_ffff; r_s2[0] = 32'd1;
    run_op(4'b1001, 10, 1'b1);
    req_valid = '0;

    // Busy timeout.
    force_busy = 1'b1;
    randomize_reqs();
    run_op(4'b0100, 2, 1'b1);
    force_busy = 1'b0;

    // Reset while the op is waiting on a busy ALU.
    randomize_reqs();
    drive_reqs(4'b0100);
    #1;
    check_eq("mid_req_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge CLK);
    #1 req_valid = '0;
    force_busy = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    force_busy = 1'b0;
    model_ptr  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    randomize_reqs();
    run_op('1, 0, 1'b1);

    // Randomized traffic.
    for (int r = 0; r < 80; r++) begin
      randomize_reqs();
      force_busy = ($urandom_range(0, 15) == 0);
      run_op(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      force_busy = 1'b0;
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
